// File: rtl/demux_buf.sv
// demux_buf: routes a 2-bit input to one of 31 single-entry lane registers with valid/ack handshake;
// sel=31 is illegal and is dropped, raising a sticky err and a saturating drop_cnt.
module demux_buf #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       sel,
   input  logic [1:0]       inp,
   input  logic             inp_valid,
   output logic             inp_ready,
   output logic [1:0]       out0,
   output logic [1:0]       out1,
   output logic [1:0]       out2,
   output logic [1:0]       out3,
   output logic [1:0]       out4,
   output logic [1:0]       out5,
   output logic [1:0]       out6,
   output logic [1:0]       out7,
   output logic [1:0]       out8,
   output logic [1:0]       out9,
   output logic [1:0]       out10,
   output logic [1:0]       out11,
   output logic [1:0]       out12,
   output logic [1:0]       out13,
   output logic [1:0]       out14,
   output logic [1:0]       out15,
   output logic [1:0]       out16,
   output logic [1:0]       out17,
   output logic [1:0]       out18,
   output logic [1:0]       out19,
   output logic [1:0]       out20,
   output logic [1:0]       out21,
   output logic [1:0]       out22,
   output logic [1:0]       out23,
   output logic [1:0]       out24,
   output logic [1:0]       out25,
   output logic [1:0]       out26,
   output logic [1:0]       out27,
   output logic [1:0]       out28,
   output logic [1:0]       out29,
   output logic [1:0]       out30,
   output logic [30:0]      out_valid,
   input  logic [30:0]      out_ack,
   input  logic             err_clr,
   output logic             err,
   output logic [CNT_W-1:0] drop_cnt
);
   typedef enum logic {EMPTY, FULL} lane_st_t;
   logic             w_illegal;
   logic             w_xfer;
   logic [31:0]      w_vpad;
   logic [31:0]      w_apad;
   logic [30:0]      w_valid;
   logic [1:0]       w_data [31];
   logic             r_err;
   logic [CNT_W-1:0] r_drop;
   // padding to 32 bits lets sel=31 index safely; that lane reads as empty
   assign w_illegal = (sel == 5'd31);
   assign w_vpad    = {1'b0, w_valid};
   assign w_apad    = {1'b0, out_ack};
   assign inp_ready = w_illegal | ~w_vpad[sel] | w_apad[sel];
   assign w_xfer    = inp_valid & inp_ready;
   for (genvar g = 0; g < 31; g++) begin : g_lane
      lane_st_t   r_st;
      lane_st_t   w_nxt;
      logic [1:0] r_data;
      logic       w_load;
      assign w_load = w_xfer & (sel == 5'(g));
      always_comb begin
         w_nxt = r_st;
         if (w_load) w_nxt = FULL;
         else if (r_st == FULL && out_ack[g]) w_nxt = EMPTY;
      end
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_st   <= EMPTY;
            r_data <= '0;
         end else begin
            r_st <= w_nxt;
            if (w_load) r_data <= inp;
         end
      end
      assign w_valid[g] = (r_st == FULL);
      assign w_data[g]  = r_data;
   end
   // a new illegal transfer wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err  <= 1'b0;
         r_drop <= '0;
      end else begin
         if (w_xfer && w_illegal) r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
         if (w_xfer && w_illegal && r_drop != '1) r_drop <= r_drop + CNT_W'(1);
      end
   end
   assign err       = r_err;
   assign drop_cnt  = r_drop;
   assign out_valid = w_valid;
   assign out0  = w_data[0];
   assign out1  = w_data[1];
   assign out2  = w_data[2];
   assign out3  = w_data[3];
   assign out4  = w_data[4];
   assign out5  = w_data[5];
   assign out6  = w_data[6];
   assign out7  = w_data[7];
   assign out8  = w_data[8];
   assign out9  = w_data[9];
   assign out10 = w_data[10];
   assign out11 = w_data[11];
   assign out12 = w_data[12];
   assign out13 = w_data[13];
   assign out14 = w_data[14];
   assign out15 = w_data[15];
   assign out16 = w_data[16];
   assign out17 = w_data[17];
   assign out18 = w_data[18];
   assign out19 = w_data[19];
   assign out20 = w_data[20];
   assign out21 = w_data[21];
   assign out22 = w_data[22];
   assign out23 = w_data[23];
   assign out24 = w_data[24];
   assign out25 = w_data[25];
   assign out26 = w_data[26];
   assign out27 = w_data[27];
   assign out28 = w_data[28];
   assign out29 = w_data[29];
   assign out30 = w_data[30];
endmodule
